// File: rtl/median_scan_sequencer_if.sv
// Bundles the loader, pixel-memory and median-memory signals of the scan
// sequencer. The master side is the sequencer. The slave side is its
// environment (loader, pixel memory and median memory).
interface median_scan_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              writeMem;
  logic [ADDR_W-1:0] xAddressIn;
  logic [ADDR_W-1:0] yAddressIn;
  logic              dataIn;

  logic              memWrite;
  logic              memRead;
  logic [ADDR_W-1:0] memXAddr;
  logic [ADDR_W-1:0] memYAddr;
  logic              memWData;
  logic              memRData;

  logic [ADDR_W-1:0] xAddressOutMedianMem;
  logic [ADDR_W-1:0] yAddressOutMedianMem;
  logic              writeMedianMem;
  logic              writeMedianData;

  modport master (
    input  writeMem, xAddressIn, yAddressIn, dataIn, memRData,
    output memWrite, memRead, memXAddr, memYAddr, memWData,
    output xAddressOutMedianMem, yAddressOutMedianMem, writeMedianMem, writeMedianData
  );

  modport slave (
    output writeMem, xAddressIn, yAddressIn, dataIn, memRData,
    input  memWrite, memRead, memXAddr, memYAddr, memWData,
    input  xAddressOutMedianMem, yAddressOutMedianMem, writeMedianMem, writeMedianData
  );
endinterface

// File: rtl/median_scan_sequencer.sv
// 3x3 binary median scan sequencer. It shares a single-port 1-bit pixel memory
// with an external loader. It walks every centre (y inner, x outer), gathers the
// zero-padded 3x3 neighbourhood, and emits the majority bit to the median memory.
// It counts median=1 windows and reports wakeUp at the end of each frame.
module median_scan_sequencer #(
  parameter int IMG_W  = 240,
  parameter int IMG_H  = 180,
  parameter int ADDR_W = 8,
  parameter int THR_W  = 13,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  median_scan_sequencer_if.master bus,
  input  logic                 start,
  input  logic [THR_W-1:0]     threshold,
  output logic [CNT_W-1:0]     activeWindows,
  output logic                 busy,
  output logic                 loadReject,
  output logic                 fullImageDone,
  output logic                 wakeUp
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EMIT, DONE} stateT;

  localparam logic [ADDR_W-1:0]        X_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0]        Y_LAST = ADDR_W'(IMG_H - 1);
  localparam logic signed [ADDR_W+1:0] W_S    = (ADDR_W+2)'(IMG_W);
  localparam logic signed [ADDR_W+1:0] H_S    = (ADDR_W+2)'(IMG_H);
  localparam logic signed [ADDR_W+1:0] ONE_S  = (ADDR_W+2)'(1);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  // Majority of nine taps: at least five ones.
  function automatic logic majority(input logic [3:0] s);
    return s >= 4'd5;
  endfunction

  stateT             state, stateNext;
  logic [1:0]        kCol, kRow;
  logic [ADDR_W-1:0] cx, cy;
  logic              startPrev;
  logic              startEdge;
  logic              lastTap, lastCentre;

  logic signed [ADDR_W+1:0] nX, nY;
  logic              tapInRange;

  logic              memWriteC, memReadC, memWDataC;
  logic [ADDR_W-1:0] memXC, memYC;

  logic              rdVld_p1;
  logic [3:0]        sum_p1;
  logic [3:0]        sumNext;
  logic              tapBit;

  logic [ADDR_W-1:0] medX_p2, medY_p2;
  logic              medBit_p2, medStrobe_p2;
  logic [CNT_W-1:0]  cntNext;

  assign startEdge  = start & ~startPrev;
  assign lastTap    = (kCol == 2'd2) && (kRow == 2'd2);
  assign lastCentre = (cx == X_LAST) && (cy == Y_LAST);

  // Stage p0: neighbour address = centre + (kCol-1, kRow-1), signed so borders go negative
  assign nX = $signed({2'b00, cx}) + $signed({{ADDR_W{1'b0}}, kCol}) - ONE_S;
  assign nY = $signed({2'b00, cy}) + $signed({{ADDR_W{1'b0}}, kRow}) - ONE_S;
  assign tapInRange = (nX >= 0) && (nX < W_S) && (nY >= 0) && (nY < H_S);

  // Stage p1: fold in the bit returned for last cycle's in-range read
  assign tapBit  = rdVld_p1 & bus.memRData;
  assign sumNext = sum_p1 + {3'b000, tapBit};
  assign cntNext = satInc(activeWindows, medBit_p2);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next state, plus memory ownership: the loader in IDLE/DONE, the scan otherwise.
  always_comb begin
    stateNext  = state;
    busy       = 1'b0;
    loadReject = 1'b0;
    memWriteC  = 1'b0;
    memReadC   = 1'b0;
    memWDataC  = 1'b0;
    memXC      = '0;
    memYC      = '0;
    case (state)
      IDLE, DONE: begin
        memWriteC = bus.writeMem;
        memXC     = bus.xAddressIn;
        memYC     = bus.yAddressIn;
        memWDataC = bus.dataIn;
        if (startEdge) stateNext = FETCH;
      end
      FETCH: begin
        busy       = 1'b1;
        loadReject = bus.writeMem;
        memReadC   = tapInRange;
        if (tapInRange) begin
          memXC = nX[ADDR_W-1:0];
          memYC = nY[ADDR_W-1:0];
        end
        if (lastTap) stateNext = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        loadReject = bus.writeMem;
        stateNext  = EMIT;
      end
      EMIT: begin
        busy       = 1'b1;
        loadReject = bus.writeMem;
        stateNext  = lastCentre ? DONE : FETCH;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Tap and centre counters, result registers, frame count and wakeUp. startPrev
  // samples start during reset, so a start level held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      startPrev     <= start;
      kCol          <= '0;
      kRow          <= '0;
      cx            <= '0;
      cy            <= '0;
      rdVld_p1      <= 1'b0;
      medStrobe_p2  <= 1'b0;
      medBit_p2     <= 1'b0;
      medX_p2       <= '0;
      medY_p2       <= '0;
      activeWindows <= '0;
      fullImageDone <= 1'b0;
      wakeUp        <= 1'b0;
    end else begin
      startPrev     <= start;
      rdVld_p1      <= memReadC;
      medStrobe_p2  <= 1'b0;
      fullImageDone <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (startEdge) begin
            kCol          <= '0;
            kRow          <= '0;
            cx            <= '0;
            cy            <= '0;
            activeWindows <= '0;
            wakeUp        <= 1'b0;
          end
        end
        FETCH: begin
          if (kCol == 2'd2) begin
            kCol <= '0;
            kRow <= lastTap ? 2'd0 : kRow + 2'd1;
          end else begin
            kCol <= kCol + 2'd1;
          end
        end
        DRAIN: begin
          medStrobe_p2 <= 1'b1;
          medBit_p2    <= majority(sumNext);
          medX_p2      <= cx;
          medY_p2      <= cy;
        end
        EMIT: begin
          activeWindows <= cntNext;
          if (cy == Y_LAST) begin
            cy <= '0;
            if (cx == X_LAST) begin
              fullImageDone <= 1'b1;
              wakeUp <= ({{THR_W{1'b0}}, cntNext} >= {{CNT_W{1'b0}}, threshold});
            end else begin
              cx <= cx + 1'b1;
            end
          end else begin
            cy <= cy + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Neighbourhood sum: restarted on the first tap, accumulated through DRAIN.
  always_ff @(posedge clk) begin
    if (state == FETCH && kCol == 2'd0 && kRow == 2'd0) sum_p1 <= '0;
    else if (state == FETCH || state == DRAIN)          sum_p1 <= sumNext;
  end

  // Stage p2: result presented during EMIT, held afterwards
  assign bus.memWrite             = memWriteC;
  assign bus.memRead              = memReadC;
  assign bus.memXAddr             = memXC;
  assign bus.memYAddr             = memYC;
  assign bus.memWData             = memWDataC;
  assign bus.writeMedianMem       = medStrobe_p2;
  assign bus.writeMedianData      = medBit_p2;
  assign bus.xAddressOutMedianMem = medX_p2;
  assign bus.yAddressOutMedianMem = medY_p2;

endmodule

// File: tb/tb_median_scan_sequencer.sv
// Bench for median_scan_sequencer on a reduced 8x6 image. A behavioural pixel
// memory serves the DUT. A software median model fills a queue of expected
// (x, y, bit) results that is drained as the DUT strobes writeMedianMem.
module tb_median_scan_sequencer;
  localparam int W     = 8;
  localparam int H     = 6;
  localparam int N     = W * H;
  localparam int FRAME = 11 * N;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] threshold;
  logic [15:0] activeWindows;
  logic        busy, loadReject, fullImageDone, wakeUp;

  always #5 clk = ~clk;

  median_scan_sequencer_if #(.ADDR_W(8)) bus ();

  median_scan_sequencer #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(8), .THR_W(13), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .start(start),
    .threshold(threshold),
    .activeWindows(activeWindows),
    .busy(busy),
    .loadReject(loadReject),
    .fullImageDone(fullImageDone),
    .wakeUp(wakeUp)
  );

  // Single-port pixel memory; read data appears one cycle after memRead.
  bit   mem [256][256];
  logic rdData = 1'b0;
  always @(posedge clk) begin
    if (bus.memRead)  rdData <= mem[bus.memXAddr][bus.memYAddr];
    if (bus.memWrite) mem[bus.memXAddr][bus.memYAddr] <= bus.memWData;
  end
  assign bus.memRData = rdData;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       b;
  } exp_t;

  bit   img [W][H];
  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic bit model_med(int x, int y);
    int s = 0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++)
        if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
          s += int'(img[x + dx][y + dy]);
    return s >= 5;
  endfunction

  task automatic push_expect(output int ones);
    bit b;
    ones = 0;
    q.delete();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) begin
        b = model_med(x, y);
        q.push_back('{8'(x), 8'(y), b});
        ones += int'(b);
      end
  endtask

  task automatic fill_img(input bit v);
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        img[x][y] = v;
  endtask

  task automatic load_image();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) begin
        @(negedge clk);
        bus.writeMem   = 1'b1;
        bus.xAddressIn = 8'(x);
        bus.yAddressIn = 8'(y);
        bus.dataIn     = img[x][y];
      end
    @(negedge clk);
    bus.writeMem = 1'b0;
  endtask

  task automatic kick();
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
  endtask

  // Runs until fullImageDone, checking every strobe against the queue.
  // injectAt > 0 attempts a loader write (5,5)=1 on that cycle of the scan.
  task automatic run_frame(input int injectAt, output int cyc, output int emits);
    exp_t e;
    cyc   = 0;
    emits = 0;
    while (cyc < 3 * FRAME) begin
      @(negedge clk);
      cyc++;
      bus.writeMem = 1'b0;
      if (bus.writeMedianMem === 1'b1) begin
        emits++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL emit_extra: got x=%0d y=%0d, required no strobe",
                   bus.xAddressOutMedianMem, bus.yAddressOutMedianMem);
        end else begin
          e = q.pop_front();
          if ({bus.xAddressOutMedianMem, bus.yAddressOutMedianMem, bus.writeMedianData} !== {e.x, e.y, e.b}) begin
            bad++;
            $display("FAIL emit: got x=%0d y=%0d bit=%0b, required x=%0d y=%0d bit=%0b",
                     bus.xAddressOutMedianMem, bus.yAddressOutMedianMem, bus.writeMedianData,
                     e.x, e.y, e.b);
          end
        end
      end
      if (injectAt > 0 && cyc == injectAt) begin
        bus.writeMem   = 1'b1;
        bus.xAddressIn = 8'd5;
        bus.yAddressIn = 8'd5;
        bus.dataIn     = 1'b1;
        #1;
        total++;
        if ({loadReject, bus.memWrite} !== 2'b10) begin
          bad++;
          $display("FAIL busy_write: got loadReject=%0b memWrite=%0b, required 1 0",
                   loadReject, bus.memWrite);
        end
      end
      if (fullImageDone === 1'b1) break;
    end
    total++;
    if (fullImageDone !== 1'b1) begin
      bad++;
      $display("FAIL frame_timeout: got fullImageDone=%0b after %0d cycles, required 1", fullImageDone, cyc);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL emit_missing: got %0d results outstanding, required 0", q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, fullImageDone, wakeUp, bus.writeMedianMem, bus.memRead, activeWindows} !== 21'd0) begin
      bad++;
      $display("FAIL reset_state: got busy=%0b done=%0b wake=%0b wmm=%0b rd=%0b cnt=%0d, required all 0",
               busy, fullImageDone, wakeUp, bus.writeMedianMem, bus.memRead, activeWindows);
    end
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_through_reset: got busy=%0b, required 0", busy);
    end
    start = 1'b0;
  endtask

  task automatic test_all_zero();
    int ones, cyc, emits;
    @(negedge clk);
    bus.writeMem = 1'b1; bus.xAddressIn = 8'd3; bus.yAddressIn = 8'd2; bus.dataIn = 1'b1;
    #1;
    total++;
    if ({bus.memWrite, bus.memXAddr, bus.memYAddr, bus.memWData, bus.memRead, loadReject} !== {1'b1, 8'd3, 8'd2, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL idle_passthrough: got we=%0b x=%0d y=%0d d=%0b rd=%0b rej=%0b, required 1 3 2 1 0 0",
               bus.memWrite, bus.memXAddr, bus.memYAddr, bus.memWData, bus.memRead, loadReject);
    end
    fill_img(1'b0);
    load_image();
    threshold = 13'd5;
    push_expect(ones);
    kick();
    run_frame(0, cyc, emits);
    // The first counted negedge follows the edge that samples start, so the
    // frame spans FRAME clock edges and done is seen on negedge FRAME+1.
    total++;
    if (cyc != FRAME + 1) begin
      bad++;
      $display("FAIL frame_length: got %0d, required %0d", cyc, FRAME + 1);
    end
    total++;
    if (emits != N) begin
      bad++;
      $display("FAIL zero_emits: got %0d, required %0d", emits, N);
    end
    total++;
    if ({activeWindows, wakeUp} !== {16'd0, 1'b0}) begin
      bad++;
      $display("FAIL zero_result: got cnt=%0d wake=%0b, required 0 0", activeWindows, wakeUp);
    end
    @(negedge clk);
    total++;
    if ({fullImageDone, busy, wakeUp} !== 3'b000) begin
      bad++;
      $display("FAIL done_pulse: got done=%0b busy=%0b wake=%0b, required 0 0 0", fullImageDone, busy, wakeUp);
    end
  endtask

  task automatic test_all_ones();
    int ones, cyc, emits;
    fill_img(1'b1);
    load_image();
    threshold = 13'(N - 4);
    push_expect(ones);
    kick();
    run_frame(0, cyc, emits);
    total++;
    if ({activeWindows, wakeUp} !== {16'(N - 4), 1'b1}) begin
      bad++;
      $display("FAIL ones_result: got cnt=%0d wake=%0b, required %0d 1", activeWindows, wakeUp, N - 4);
    end
  endtask

  task automatic test_patterns();
    int ones, cyc, emits;
    bit expWake;
    for (int p = 0; p < 4; p++) begin
      fill_img(1'b0);
      case (p)
        0: img[1][1] = 1'b1;
        1: begin img[1][0] = 1'b1; img[1][1] = 1'b1; img[1][2] = 1'b1; end
        2: for (int x = 0; x < 3; x++) for (int y = 0; y < 3; y++) img[x][y] = 1'b1;
        default: for (int x = 0; x < W; x++) for (int y = 0; y < H; y++) img[x][y] = 1'($urandom_range(0, 1));
      endcase
      load_image();
      push_expect(ones);
      threshold = (p % 2 == 0) ? 13'(ones) : 13'(ones + 1);
      expWake   = (p % 2 == 0);
      kick();
      run_frame(0, cyc, emits);
      total++;
      if ({activeWindows, wakeUp} !== {16'(ones), expWake}) begin
        bad++;
        $display("FAIL pattern%0d_result: got cnt=%0d wake=%0b, required %0d %0b",
                 p, activeWindows, wakeUp, ones, expWake);
      end
    end
  endtask

  task automatic test_write_during_scan();
    int ones, cyc, emits;
    fill_img(1'b0);
    load_image();
    threshold = 13'd1;
    push_expect(ones);
    kick();
    run_frame(100, cyc, emits);
    total++;
    if ({mem[8'd5][8'd5], activeWindows, wakeUp} !== {1'b0, 16'd0, 1'b0}) begin
      bad++;
      $display("FAIL busy_write_memory: got mem55=%0b cnt=%0d wake=%0b, required 0 0 0",
               mem[8'd5][8'd5], activeWindows, wakeUp);
    end
  endtask

  task automatic test_reset_mid_scan();
    int ones, cyc, emits, strobes;
    fill_img(1'b1);
    load_image();
    threshold = 13'd1;
    push_expect(ones);
    kick();
    repeat (200) @(negedge clk);
    total++;
    if (activeWindows === 16'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_scan_progress: got cnt=%0d busy=%0b, required nonzero 1", activeWindows, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, fullImageDone, wakeUp, bus.writeMedianMem, activeWindows} !== 20'd0) begin
      bad++;
      $display("FAIL mid_reset_state: got busy=%0b done=%0b wake=%0b wmm=%0b cnt=%0d, required all 0",
               busy, fullImageDone, wakeUp, bus.writeMedianMem, activeWindows);
    end
    reset   = 1'b0;
    strobes = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.writeMedianMem === 1'b1 || busy === 1'b1) strobes++;
    end
    total++;
    if (strobes != 0) begin
      bad++;
      $display("FAIL after_reset_activity: got %0d active cycles, required 0", strobes);
    end
    push_expect(ones);
    kick();
    run_frame(0, cyc, emits);
    total++;
    if ({emits, activeWindows} !== {32'(N), 16'(N - 4)}) begin
      bad++;
      $display("FAIL restart_frame: got emits=%0d cnt=%0d, required %0d %0d", emits, activeWindows, N, N - 4);
    end
  endtask

  task automatic test_start_hold();
    int ones, cyc, emits, busyCycles;
    busyCycles = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy === 1'b1) busyCycles++;
    end
    fill_img(1'b0);
    load_image();
    total++;
    if ({busyCycles, wakeUp} !== {32'd0, 1'b1}) begin
      bad++;
      $display("FAIL start_held: got busyCycles=%0d wake=%0b, required 0 1", busyCycles, wakeUp);
    end
    threshold = 13'd0;
    push_expect(ones);
    kick();
    @(negedge clk);
    total++;
    if ({busy, wakeUp, activeWindows} !== {1'b1, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL second_edge: got busy=%0b wake=%0b cnt=%0d, required 1 0 0", busy, wakeUp, activeWindows);
    end
    run_frame(0, cyc, emits);
    total++;
    if ({activeWindows, wakeUp} !== {16'd0, 1'b1}) begin
      bad++;
      $display("FAIL thr_zero: got cnt=%0d wake=%0b, required 0 1", activeWindows, wakeUp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b1;
    threshold      = '0;
    bus.writeMem   = 1'b0;
    bus.xAddressIn = '0;
    bus.yAddressIn = '0;
    bus.dataIn     = 1'b0;
    test_reset();
    test_all_zero();
    test_all_ones();
    test_patterns();
    test_write_during_scan();
    test_reset_mid_scan();
    test_start_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
